// File: rtl/csi2_packet_decoder.sv
// CSI-2 packet decoder: parses ECC-protected headers from aligned lane byte pairs, emits sync
// pulses and 16-bit payload beats. Define CSI2_CRC_CHECK_EN to enable payload CRC checking.
module csi2_packet_decoder #(
    parameter logic [3:0]  VC_MASK = 4'b0001,
    parameter logic [15:0] MAX_WC  = 16'd8192
) (
    input  logic        byte_clk,
    input  logic        reset,
    input  logic [7:0]  lane0_byte,
    input  logic [7:0]  lane1_byte,
    input  logic        byte_valid,
    input  logic        sot,
    input  logic        eot,
    output logic        frame_start,
    output logic        frame_end,
    output logic        line_start,
    output logic        line_end,
    output logic        hdr_valid,
    output logic [1:0]  virt_chan,
    output logic [5:0]  data_type,
    output logic [15:0] word_count,
    output logic [15:0] pix_data,
    output logic        pix_valid,
    output logic [1:0]  pix_be,
    output logic        pix_last,
    output logic        ecc_err,
    output logic        len_err,
    output logic        crc_err,
    output logic [2:0]  dbg_state
);

    // Handshake: a beat is consumed on every cycle byte_valid is high (no backpressure);
    // pix_valid qualifies pix_data/pix_be/pix_last for exactly that one output cycle.

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_HDR      = 3'd1,
        S_PAYLOAD  = 3'd2,
        S_CRC      = 3'd3,
        S_CRC_HI   = 3'd4,
        S_WAIT_EOT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  di_q, di_d;
    logic [7:0]  wc_lo_q, wc_lo_d;
    logic [15:0] rem_q, rem_d;
    logic [1:0]  vc_d;
    logic [5:0]  dt_d;
    logic [15:0] wc_d;
    logic [15:0] pix_data_d;
    logic        pix_valid_d;
    logic [1:0]  pix_be_d;
    logic        pix_last_d;
    logic [3:0]  sync_d;
    logic        hdr_valid_d;
    logic        ecc_err_d;
    logic        len_err_d;

    logic [15:0] hdr_wc;
    logic [1:0]  hdr_vc;
    logic [5:0]  hdr_dt;
    logic        ecc_ok;
    logic        in_packet;

    // Bit d[0] is DI bit 0, d[23] is WC bit 15.
    function automatic logic [5:0] hdr_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return p;
    endfunction

`ifdef CSI2_CRC_CHECK_EN
    logic [15:0] crc_acc_q, crc_acc_d;
    logic [7:0]  crc_lo_q, crc_lo_d;
    logic        crc_err_d;

    // Reflected CRC-16/CCITT, data bits taken LSB first.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 16'h8408;
            else             r = r >> 1;
        end
        return r;
    endfunction
`endif

    assign hdr_wc    = {lane0_byte, wc_lo_q};
    assign hdr_vc    = di_q[7:6];
    assign hdr_dt    = di_q[5:0];
    assign ecc_ok    = (lane1_byte[7:6] == 2'b00) &&
                       (lane1_byte[5:0] == hdr_ecc({lane0_byte, wc_lo_q, di_q}));
    assign in_packet = (state_q == S_HDR) || (state_q == S_PAYLOAD) ||
                       (state_q == S_CRC) || (state_q == S_CRC_HI);
    assign dbg_state = state_q;

    always_comb begin
        state_d     = state_q;
        di_d        = di_q;
        wc_lo_d     = wc_lo_q;
        rem_d       = rem_q;
        vc_d        = virt_chan;
        dt_d        = data_type;
        wc_d        = word_count;
        pix_data_d  = pix_data;
        pix_valid_d = 1'b0;
        pix_be_d    = 2'b00;
        pix_last_d  = 1'b0;
        sync_d      = 4'b0000;
        hdr_valid_d = 1'b0;
        ecc_err_d   = 1'b0;
        len_err_d   = 1'b0;
`ifdef CSI2_CRC_CHECK_EN
        crc_acc_d   = crc_acc_q;
        crc_lo_d    = crc_lo_q;
        crc_err_d   = 1'b0;
`endif
        // A new sot always wins; it truncates anything still in flight.
        if (byte_valid && sot) begin
            len_err_d = (state_q != S_IDLE) && (state_q != S_WAIT_EOT);
            di_d      = lane0_byte;
            wc_lo_d   = lane1_byte;
            state_d   = S_HDR;
        end else if (eot && in_packet) begin
            len_err_d = 1'b1;
            state_d   = S_IDLE;
        end else if (state_q == S_WAIT_EOT) begin
            if (eot) state_d = S_IDLE;
        end else if (byte_valid) begin
            case (state_q)
                S_HDR: begin
                    if (!ecc_ok) begin
                        ecc_err_d = 1'b1;
                        state_d   = S_WAIT_EOT;
                    end else if (!VC_MASK[hdr_vc]) begin
                        state_d   = S_WAIT_EOT;
                    end else if (hdr_dt <= 6'h0F) begin
                        hdr_valid_d = 1'b1;
                        vc_d        = hdr_vc;
                        dt_d        = hdr_dt;
                        wc_d        = hdr_wc;
                        if (hdr_dt < 6'h04) sync_d[hdr_dt[1:0]] = 1'b1;
                        state_d     = S_WAIT_EOT;
                    end else if (hdr_wc > MAX_WC) begin
                        len_err_d = 1'b1;
                        state_d   = S_WAIT_EOT;
                    end else begin
                        hdr_valid_d = 1'b1;
                        vc_d        = hdr_vc;
                        dt_d        = hdr_dt;
                        wc_d        = hdr_wc;
                        rem_d       = hdr_wc;
                        state_d     = (hdr_wc == 16'd0) ? S_CRC : S_PAYLOAD;
`ifdef CSI2_CRC_CHECK_EN
                        crc_acc_d   = 16'hFFFF;
`endif
                    end
                end
                S_PAYLOAD: begin
                    pix_valid_d = 1'b1;
                    if (rem_q == 16'd1) begin
                        // Odd tail: lane1 already carries the low CRC byte.
                        pix_data_d = {8'h00, lane0_byte};
                        pix_be_d   = 2'b01;
                        pix_last_d = 1'b1;
                        rem_d      = 16'd0;
                        state_d    = S_CRC_HI;
`ifdef CSI2_CRC_CHECK_EN
                        crc_acc_d  = crc_byte(crc_acc_q, lane0_byte);
                        crc_lo_d   = lane1_byte;
`endif
                    end else begin
                        pix_data_d = {lane1_byte, lane0_byte};
                        pix_be_d   = 2'b11;
`ifdef CSI2_CRC_CHECK_EN
                        crc_acc_d  = crc_byte(crc_byte(crc_acc_q, lane0_byte), lane1_byte);
`endif
                        if (rem_q == 16'd2) begin
                            pix_last_d = 1'b1;
                            rem_d      = 16'd0;
                            state_d    = S_CRC;
                        end else begin
                            rem_d      = rem_q - 16'd2;
                        end
                    end
                end
                S_CRC: begin
                    state_d = S_WAIT_EOT;
`ifdef CSI2_CRC_CHECK_EN
                    crc_err_d = ({lane1_byte, lane0_byte} != 16'h0000) &&
                                ({lane1_byte, lane0_byte} != crc_acc_q);
`endif
                end
                S_CRC_HI: begin
                    state_d = S_WAIT_EOT;
`ifdef CSI2_CRC_CHECK_EN
                    crc_err_d = ({lane0_byte, crc_lo_q} != 16'h0000) &&
                                ({lane0_byte, crc_lo_q} != crc_acc_q);
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge byte_clk or negedge reset) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge byte_clk or negedge reset) begin
        if (!reset) begin
            di_q        <= '0;
            wc_lo_q     <= '0;
            rem_q       <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            hdr_valid   <= 1'b0;
            virt_chan   <= '0;
            data_type   <= '0;
            word_count  <= '0;
            pix_data    <= '0;
            pix_valid   <= 1'b0;
            pix_be      <= '0;
            pix_last    <= 1'b0;
            ecc_err     <= 1'b0;
            len_err     <= 1'b0;
        end else begin
            di_q        <= di_d;
            wc_lo_q     <= wc_lo_d;
            rem_q       <= rem_d;
            frame_start <= sync_d[0];
            frame_end   <= sync_d[1];
            line_start  <= sync_d[2];
            line_end    <= sync_d[3];
            hdr_valid   <= hdr_valid_d;
            virt_chan   <= vc_d;
            data_type   <= dt_d;
            word_count  <= wc_d;
            pix_data    <= pix_data_d;
            pix_valid   <= pix_valid_d;
            pix_be      <= pix_be_d;
            pix_last    <= pix_last_d;
            ecc_err     <= ecc_err_d;
            len_err     <= len_err_d;
        end
    end

`ifdef CSI2_CRC_CHECK_EN
    always_ff @(posedge byte_clk or negedge reset) begin
        if (!reset) begin
            crc_acc_q <= '0;
            crc_lo_q  <= '0;
            crc_err   <= 1'b0;
        end else begin
            crc_acc_q <= crc_acc_d;
            crc_lo_q  <= crc_lo_d;
            crc_err   <= crc_err_d;
        end
    end
`else
    assign crc_err = 1'b0;
`endif

endmodule

// File: tb/tb_csi2_packet_decoder.sv
// Directed self-checking bench for csi2_packet_decoder; header ECC bytes are hand-computed.
module tb_csi2_packet_decoder;

    logic        byte_clk = 1'b0;
    logic        reset;
    logic [7:0]  lane0_byte, lane1_byte;
    logic        byte_valid, sot, eot;
    logic        frame_start, frame_end, line_start, line_end, hdr_valid;
    logic [1:0]  virt_chan;
    logic [5:0]  data_type;
    logic [15:0] word_count, pix_data;
    logic        pix_valid, pix_last, ecc_err, len_err, crc_err;
    logic [1:0]  pix_be;
    logic [2:0]  dbg_state;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_CRC = 3'd3, ST_CRC_HI = 3'd4, ST_WAIT = 3'd5;
`ifdef CSI2_CRC_CHECK_EN
    localparam int CRC_ON = 1;
`else
    localparam int CRC_ON = 0;
`endif

    always #5 byte_clk = ~byte_clk;

    csi2_packet_decoder dut (
        .byte_clk(byte_clk), .reset(reset),
        .lane0_byte(lane0_byte), .lane1_byte(lane1_byte),
        .byte_valid(byte_valid), .sot(sot), .eot(eot),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .hdr_valid(hdr_valid), .virt_chan(virt_chan), .data_type(data_type),
        .word_count(word_count), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_be(pix_be), .pix_last(pix_last), .ecc_err(ecc_err),
        .len_err(len_err), .crc_err(crc_err), .dbg_state(dbg_state)
    );

    int n_checks = 0, n_bad = 0;
    int n_fs, n_fe, n_ls, n_le, n_hdr, n_ecc, n_len, n_crc;
    logic [18:0] exp_q[$];
    logic [18:0] got_q[$];
    logic [15:0] run_crc;
    logic [7:0]  sync_ecc [4];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard capture: outputs sampled shortly after each active edge.
    always @(posedge byte_clk) begin
        #2;
        if (reset === 1'b1) begin
            n_fs  += int'(frame_start);
            n_fe  += int'(frame_end);
            n_ls  += int'(line_start);
            n_le  += int'(line_end);
            n_hdr += int'(hdr_valid);
            n_ecc += int'(ecc_err);
            n_len += int'(len_err);
            n_crc += int'(crc_err);
            if (pix_valid) got_q.push_back({pix_last, pix_be, pix_data});
        end
    end

    // Byte-wise reflected CRC-16/CCITT reference.
    function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        return r;
    endfunction

    task automatic clear_counts();
        n_fs = 0; n_fe = 0; n_ls = 0; n_le = 0;
        n_hdr = 0; n_ecc = 0; n_len = 0; n_crc = 0;
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic beat(input logic [7:0] l0, input logic [7:0] l1, input logic s);
        @(negedge byte_clk);
        lane0_byte = l0; lane1_byte = l1; byte_valid = 1'b1; sot = s; eot = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge byte_clk);
            byte_valid = 1'b0; sot = 1'b0; eot = 1'b0;
        end
    endtask

    task automatic end_burst();
        @(negedge byte_clk);
        byte_valid = 1'b0; sot = 1'b0; eot = 1'b1;
        @(negedge byte_clk);
        eot = 1'b0;
        idle(2);
    endtask

    task automatic send_hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
        beat(di, wc[7:0], 1'b1);
        beat(wc[15:8], ecc, 1'b0);
        run_crc = 16'hFFFF;
    endtask

    task automatic pay_beat(input logic [7:0] l0, input logic [7:0] l1, input logic last);
        run_crc = crc_upd(crc_upd(run_crc, l0), l1);
        beat(l0, l1, 1'b0);
        exp_q.push_back({last, 2'b11, l1, l0});
    endtask

    task automatic pay_odd(input logic [7:0] l0);
        run_crc = crc_upd(run_crc, l0);
        beat(l0, run_crc[7:0], 1'b0);
        exp_q.push_back({1'b1, 2'b01, run_crc[7:0], l0});
    endtask

    task automatic send_crc(input logic [15:0] flip);
        logic [15:0] c;
        c = run_crc ^ flip;
        beat(c[7:0], c[15:8], 1'b0);
    endtask

    task automatic check_counts(input string tag, input logic [7:0] h, input logic [7:0] e,
                                input logic [7:0] l, input logic [7:0] c);
        check_eq({tag, "_cnt"}, {n_hdr[7:0], n_ecc[7:0], n_len[7:0], n_crc[7:0]}, {h, e, l, c});
    endtask

    task automatic check_pix(input string tag);
        logic [18:0] g, e;
        check_eq({tag, "_pixn"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            if (e[17:16] == 2'b01) begin
                g[15:8] = 8'h00;
                e[15:8] = 8'h00;
            end
            check_eq({tag, "_pix"}, g, e);
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic send_raw6();
        send_hdr(8'h2A, 16'd6, 8'h2F);
        pay_beat(8'h11, 8'h22, 1'b0);
        pay_beat(8'h33, 8'h44, 1'b0);
        pay_beat(8'h55, 8'h66, 1'b1);
        send_crc(16'h0000);
    endtask

    initial begin
        sync_ecc[0] = 8'h1A; sync_ecc[1] = 8'h1D; sync_ecc[2] = 8'h11; sync_ecc[3] = 8'h16;
        reset = 1'b0; lane0_byte = '0; lane1_byte = '0; byte_valid = 1'b0; sot = 1'b0; eot = 1'b0;
        clear_counts();
        repeat (3) @(negedge byte_clk);
        check_eq("rst_out", {frame_start, frame_end, line_start, line_end, hdr_valid, pix_valid,
                             pix_last, ecc_err, len_err, crc_err, pix_be}, 32'h0);
        check_eq("rst_hdr", {virt_chan, data_type, word_count}, 32'h0);
        check_eq("rst_pix", pix_data, 32'h0);
        check_eq("rst_state", dbg_state, ST_IDLE);
        @(negedge byte_clk);
        reset = 1'b1;
        idle(2);

        // Valid beats without sot are ignored in IDLE.
        clear_counts();
        beat(8'h00, 8'h01, 1'b0);
        beat(8'h00, 8'h1A, 1'b0);
        idle(3);
        check_counts("nosot", 0, 0, 0, 0);
        check_eq("nosot_st", dbg_state, ST_IDLE);

        // Frame start: exact one-cycle latency and pulse width.
        clear_counts();
        send_hdr(8'h00, 16'h0001, 8'h1A);
        @(negedge byte_clk);
        byte_valid = 1'b0; eot = 1'b1;
        check_eq("fs_pulse", {hdr_valid, frame_start}, 32'h3);
        check_eq("fs_wc", word_count, 32'h1);
        check_eq("fs_st", dbg_state, ST_WAIT);
        @(negedge byte_clk);
        eot = 1'b0;
        check_eq("fs_once", {hdr_valid, frame_start}, 32'h0);
        check_eq("fs_idle", dbg_state, ST_IDLE);
        idle(2);
        check_eq("fs_sync", {n_fs[7:0], n_fe[7:0], n_ls[7:0], n_le[7:0]}, 32'h01000000);

        // Frame end, line start, line end.
        for (int k = 1; k < 4; k++) begin
            clear_counts();
            send_hdr(8'(k), 16'h0001, sync_ecc[k]);
            end_burst();
            check_eq("sync_k", {n_fs[7:0], n_fe[7:0], n_ls[7:0], n_le[7:0]},
                     32'h1 << (8 * (3 - k)));
            check_eq("sync_dt", {26'h0, data_type}, 32'(k));
        end

        // RAW8, WC = 6.
        clear_counts();
        send_raw6();
        idle(1);
        check_eq("raw6_st", dbg_state, ST_WAIT);
        end_burst();
        check_counts("raw6", 1, 0, 0, 0);
        check_pix("raw6");
        check_eq("raw6_hdr", {virt_chan, data_type, word_count}, {8'h2A, 16'd6});

        // WC = 5: odd tail, CRC low on lane1, stall before CRC high.
        clear_counts();
        send_hdr(8'h2A, 16'd5, 8'h29);
        pay_beat(8'h11, 8'h22, 1'b0);
        pay_beat(8'h33, 8'h44, 1'b0);
        pay_odd(8'h55);
        idle(1);
        check_eq("odd5_st", dbg_state, ST_CRC_HI);
        beat(run_crc[15:8], 8'h00, 1'b0);
        idle(1);
        check_eq("odd5_st2", dbg_state, ST_WAIT);
        end_burst();
        check_counts("odd5", 1, 0, 0, 0);
        check_pix("odd5");
        check_eq("odd5_wc", word_count, 32'd5);

        // Flipped WC bit: ECC error, then a clean packet.
        clear_counts();
        send_hdr(8'h2A, 16'd7, 8'h2F);
        beat(8'h11, 8'h22, 1'b0);
        beat(8'h33, 8'h44, 1'b0);
        end_burst();
        check_counts("ecc", 0, 1, 0, 0);
        check_eq("ecc_pix", got_q.size(), 32'd0);
        check_eq("ecc_wc", word_count, 32'd5);
        clear_counts();
        send_raw6();
        end_burst();
        check_counts("ecc_next", 1, 0, 0, 0);
        check_pix("ecc_next");

        // VC1 masked off: silent.
        clear_counts();
        send_hdr(8'h40, 16'h0001, 8'h0C);
        end_burst();
        check_eq("vc1_sync", {n_fs[7:0], n_fe[7:0], n_ls[7:0], n_le[7:0]}, 32'h0);
        check_counts("vc1", 0, 0, 0, 0);
        check_eq("vc1_hdr", {virt_chan, data_type, word_count}, {8'h2A, 16'd6});

        // WC above MAX_WC.
        clear_counts();
        send_hdr(8'h2A, 16'h3000, 8'h20);
        beat(8'h11, 8'h22, 1'b0);
        beat(8'h33, 8'h44, 1'b0);
        end_burst();
        check_counts("big", 0, 0, 1, 0);
        check_eq("big_pix", got_q.size(), 32'd0);

        // eot after 2 of 4 payload beats.
        clear_counts();
        send_hdr(8'h2A, 16'd8, 8'h35);
        pay_beat(8'h11, 8'h22, 1'b0);
        pay_beat(8'h33, 8'h44, 1'b0);
        end_burst();
        check_counts("trunc", 1, 0, 1, 0);
        check_pix("trunc");
        check_eq("trunc_st", dbg_state, ST_IDLE);

        // WC = 4 with stalls and a good CRC.
        clear_counts();
        send_hdr(8'h2A, 16'd4, 8'h33);
        pay_beat(8'hA1, 8'hB2, 1'b0);
        idle(2);
        pay_beat(8'hC3, 8'hD4, 1'b1);
        idle(1);
        send_crc(16'h0000);
        end_burst();
        check_counts("good4", 1, 0, 0, 0);
        check_pix("good4");

        // CRC of 0x0000 means not computed.
        clear_counts();
        send_hdr(8'h2A, 16'd4, 8'h33);
        pay_beat(8'h01, 8'h02, 1'b0);
        pay_beat(8'h03, 8'h04, 1'b1);
        beat(8'h00, 8'h00, 1'b0);
        end_burst();
        check_counts("zero4", 1, 0, 0, 0);
        check_pix("zero4");

        // Bad CRC on WC = 4.
        clear_counts();
        send_hdr(8'h2A, 16'd4, 8'h33);
        pay_beat(8'h11, 8'h22, 1'b0);
        pay_beat(8'h33, 8'h44, 1'b1);
        send_crc(16'h0001);
        end_burst();
        check_counts("bad4", 1, 0, 0, 8'(CRC_ON));
        check_pix("bad4");

        // Long packet with WC = 0 goes straight to CRC.
        clear_counts();
        send_hdr(8'h2A, 16'd0, 8'h10);
        idle(1);
        check_eq("wc0_st", dbg_state, ST_CRC);
        beat(8'hFF, 8'hFF, 1'b0);
        idle(1);
        check_eq("wc0_st2", dbg_state, ST_WAIT);
        end_burst();
        check_counts("wc0", 1, 0, 0, 0);
        check_eq("wc0_pix", got_q.size(), 32'd0);
        check_eq("wc0_wc", word_count, 32'd0);

        // sot mid-payload restarts with the new header.
        clear_counts();
        send_hdr(8'h2A, 16'd6, 8'h2F);
        pay_beat(8'h11, 8'h22, 1'b0);
        send_hdr(8'h00, 16'h0001, 8'h1A);
        end_burst();
        check_counts("resot", 2, 0, 1, 0);
        check_eq("resot_fs", n_fs, 32'd1);
        check_pix("resot");

        // Asynchronous reset mid-payload.
        clear_counts();
        send_hdr(8'h2A, 16'd6, 8'h2F);
        pay_beat(8'h11, 8'h22, 1'b0);
        @(negedge byte_clk);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_eq("arst_st", dbg_state, ST_IDLE);
        check_eq("arst_pix", {pix_valid, hdr_valid, word_count}, 32'h0);
        @(negedge byte_clk);
        reset = 1'b1;
        idle(2);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
